// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller (master) and the datapath/memories (slave).
// Carries opcode, flags, memory ready handshakes, control strobes, mux selects and the retire count.
interface multicycle_control_if;
  logic [10:0] opCode;
  logic        zeroCU;
  logic        imemReady;
  logic        dmemReady;
  logic        imemRd;
  logic        irWr;
  logic        pcWr;
  logic        nextPc;
  logic        reg2Loc;
  logic        regWr;
  logic        aluSrc;
  logic [1:0]  seu;
  logic        memRd;
  logic        memWr;
  logic [2:0]  aluOp;
  logic        memToReg;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  opCode, zeroCU, imemReady, dmemReady,
    output imemRd, irWr, pcWr, nextPc, reg2Loc, regWr, aluSrc, seu,
           memRd, memWr, aluOp, memToReg, illegal, retired
  );

  modport slave (
    output opCode, zeroCU, imemReady, dmemReady,
    input  imemRd, irWr, pcWr, nextPc, reg2Loc, regWr, aluSrc, seu,
           memRd, memWr, aluOp, memToReg, illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-subset controller: FETCH/DECODE/EXEC/MEM/WB FSM, 3-5 cycles per instruction.
// Stalls in FETCH/MEM with the request held while imemReady/dmemReady are low; HALT on illegal opcode.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rstN,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  typedef enum logic [2:0] {C_NONE, C_RTYPE, C_ITYPE, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B} cls_e;

  typedef struct packed {
    logic       reg2_loc;
    logic       alu_src;
    logic [1:0] seu;
    logic [2:0] alu_op;
    logic       mem_to_reg;
  } fld_t;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [2:0]  alu_q, alu_d;
  logic        run_q;
  logic [15:0] retired_q, retired_d;

  cls_e        dec_cls;
  logic [2:0]  dec_alu;
  cls_e        act_cls;
  logic [2:0]  act_alu;
  fld_t        fld;
  logic        imem_rd, ir_wr, pc_wr, next_pc, reg_wr, mem_rd, mem_wr, illegal;
  logic        retire;

  function automatic fld_t fields_of(input cls_e c, input logic [2:0] a);
    fld_t f;
    f = '0;
    case (c)
      C_RTYPE: f.alu_op = a;
      C_ITYPE: begin
        f.alu_src = 1'b1;
        f.alu_op  = a;
      end
      C_LDUR: begin
        f.alu_src    = 1'b1;
        f.seu        = 2'b01;
        f.alu_op     = 3'b010;
        f.mem_to_reg = 1'b1;
      end
      C_STUR: begin
        f.reg2_loc = 1'b1;
        f.alu_src  = 1'b1;
        f.seu      = 2'b01;
        f.alu_op   = 3'b010;
      end
      C_CBZ, C_CBNZ: begin
        f.reg2_loc = 1'b1;
        f.alu_op   = 3'b111;
        f.seu      = 2'b11;
      end
      C_B:     f.seu = 2'b10;
      default: f = '0;
    endcase
    return f;
  endfunction

  // Opcode classifier; only consulted while in DECODE, then latched for the rest of the instruction.
  always_comb begin
    dec_cls = C_NONE;
    dec_alu = 3'b000;
    if (bus.opCode[10:5] == 6'b000101) begin
      dec_cls = C_B;
    end else if (bus.opCode[10:3] == 8'b10110100) begin
      dec_cls = C_CBZ;
    end else if (bus.opCode[10:3] == 8'b10110101) begin
      dec_cls = C_CBNZ;
    end else begin
      case (bus.opCode)
        11'b10001010000: begin dec_cls = C_RTYPE; dec_alu = 3'b000; end
        11'b10001011000: begin dec_cls = C_RTYPE; dec_alu = 3'b010; end
        11'b10101010000: begin dec_cls = C_RTYPE; dec_alu = 3'b001; end
        11'b11001011000: begin dec_cls = C_RTYPE; dec_alu = 3'b110; end
        11'b11111000010: dec_cls = C_LDUR;
        11'b11111000000: dec_cls = C_STUR;
        default: begin
          case (bus.opCode[10:1])
            10'b1001001000: begin dec_cls = C_ITYPE; dec_alu = 3'b000; end
            10'b1001000100: begin dec_cls = C_ITYPE; dec_alu = 3'b010; end
            10'b1011001000: begin dec_cls = C_ITYPE; dec_alu = 3'b001; end
            10'b1101000100: begin dec_cls = C_ITYPE; dec_alu = 3'b110; end
            default:        dec_cls = C_NONE;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    act_cls = C_NONE;
    act_alu = 3'b000;
    imem_rd = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    next_pc = 1'b0;
    reg_wr  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;

    case (state_q)
      FETCH: begin
        // run_q keeps the fetch request quiet until the first edge after reset release.
        if (run_q) begin
          imem_rd = 1'b1;
          if (bus.imemReady) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        act_cls = dec_cls;
        act_alu = dec_alu;
        cls_d   = dec_cls;
        alu_d   = dec_alu;
        state_d = (dec_cls == C_NONE) ? HALT : EXEC;
      end
      EXEC: begin
        act_cls = cls_q;
        act_alu = alu_q;
        case (cls_q)
          C_RTYPE, C_ITYPE: state_d = WB;
          C_LDUR, C_STUR:   state_d = MEM;
          C_B: begin
            pc_wr   = 1'b1;
            next_pc = 1'b1;
            state_d = FETCH;
          end
          C_CBZ: begin
            pc_wr   = bus.zeroCU;
            next_pc = bus.zeroCU;
            state_d = FETCH;
          end
          C_CBNZ: begin
            pc_wr   = ~bus.zeroCU;
            next_pc = ~bus.zeroCU;
            state_d = FETCH;
          end
          default: state_d = HALT;
        endcase
      end
      MEM: begin
        act_cls = cls_q;
        act_alu = alu_q;
        mem_rd  = (cls_q == C_LDUR);
        mem_wr  = (cls_q == C_STUR);
        if (bus.dmemReady) begin
          state_d = (cls_q == C_LDUR) ? WB : FETCH;
        end
      end
      WB: begin
        act_cls = cls_q;
        act_alu = alu_q;
        reg_wr  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    fld       = fields_of(act_cls, act_alu);
    retire    = (state_d == FETCH) && (state_q inside {EXEC, MEM, WB});
    retired_d = retired_q + {15'd0, retire};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= FETCH;
      cls_q     <= C_NONE;
      alu_q     <= 3'b000;
      run_q     <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      run_q     <= 1'b1;
      retired_q <= retired_d;
    end
  end

  assign bus.imemRd   = imem_rd;
  assign bus.irWr     = ir_wr;
  assign bus.pcWr     = pc_wr;
  assign bus.nextPc   = next_pc;
  assign bus.regWr    = reg_wr;
  assign bus.memRd    = mem_rd;
  assign bus.memWr    = mem_wr;
  assign bus.illegal  = illegal;
  assign bus.reg2Loc  = fld.reg2_loc;
  assign bus.aluSrc   = fld.alu_src;
  assign bus.seu      = fld.seu;
  assign bus.aluOp    = fld.alu_op;
  assign bus.memToReg = fld.mem_to_reg;
  assign bus.retired  = retired_q;

  a_mem_excl: assert property (@(posedge clk) disable iff (!rstN) !(mem_rd && mem_wr));
  a_halt_quiet: assert property (@(posedge clk) disable iff (!rstN)
      (state_q == HALT) |-> !(imem_rd || ir_wr || pc_wr || reg_wr || mem_rd || mem_wr));

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-accurate scoreboard bench for multicycle_control: expected control vectors are queued as
// each cycle's stimulus is driven and compared against the DUT outputs mid-cycle.
module tb_multicycle_control;

  typedef enum int {K_AND, K_ADD, K_ORR, K_SUB, K_ANDI, K_ADDI, K_ORRI, K_SUBI,
                    K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_ILL} kind_e;

  typedef struct packed {
    logic       reg2Loc;
    logic       aluSrc;
    logic [1:0] seu;
    logic [2:0] aluOp;
    logic       memToReg;
  } fld_t;

  typedef struct packed {
    logic imemRd, irWr, pcWr, nextPc, regWr, memRd, memWr, illegal;
    fld_t f;
  } ctl_t;

  logic clk;
  logic rstN;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] ret_exp  = 16'd0;
  ctl_t        exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t o;
    o.imemRd     = bus.imemRd;
    o.irWr       = bus.irWr;
    o.pcWr       = bus.pcWr;
    o.nextPc     = bus.nextPc;
    o.regWr      = bus.regWr;
    o.memRd      = bus.memRd;
    o.memWr      = bus.memWr;
    o.illegal    = bus.illegal;
    o.f.reg2Loc  = bus.reg2Loc;
    o.f.aluSrc   = bus.aluSrc;
    o.f.seu      = bus.seu;
    o.f.aluOp    = bus.aluOp;
    o.f.memToReg = bus.memToReg;
    return o;
  endfunction

  function automatic fld_t fields(input kind_e k);
    fld_t f;
    f = '0;
    case (k)
      K_AND:  f.aluOp = 3'b000;
      K_ORR:  f.aluOp = 3'b001;
      K_ADD:  f.aluOp = 3'b010;
      K_SUB:  f.aluOp = 3'b110;
      K_ANDI: begin f.aluSrc = 1'b1; f.aluOp = 3'b000; end
      K_ORRI: begin f.aluSrc = 1'b1; f.aluOp = 3'b001; end
      K_ADDI: begin f.aluSrc = 1'b1; f.aluOp = 3'b010; end
      K_SUBI: begin f.aluSrc = 1'b1; f.aluOp = 3'b110; end
      K_LDUR: begin f.aluSrc = 1'b1; f.seu = 2'b01; f.aluOp = 3'b010; f.memToReg = 1'b1; end
      K_STUR: begin f.reg2Loc = 1'b1; f.aluSrc = 1'b1; f.seu = 2'b01; f.aluOp = 3'b010; end
      K_CBZ, K_CBNZ: begin f.reg2Loc = 1'b1; f.seu = 2'b11; f.aluOp = 3'b111; end
      K_B:    f.seu = 2'b10;
      default: f = '0;
    endcase
    return f;
  endfunction

  function automatic logic [10:0] opcode_of(input kind_e k);
    logic [10:0] r;
    r = 11'($urandom);
    case (k)
      K_AND:  return 11'b10001010000;
      K_ADD:  return 11'b10001011000;
      K_ORR:  return 11'b10101010000;
      K_SUB:  return 11'b11001011000;
      K_ANDI: return {10'b1001001000, r[0]};
      K_ADDI: return {10'b1001000100, r[0]};
      K_ORRI: return {10'b1011001000, r[0]};
      K_SUBI: return {10'b1101000100, r[0]};
      K_LDUR: return 11'b11111000010;
      K_STUR: return 11'b11111000000;
      K_CBZ:  return {8'b10110100, r[2:0]};
      K_CBNZ: return {8'b10110101, r[2:0]};
      K_B:    return {6'b000101, r[4:0]};
      default: return 11'b11111111111;
    endcase
  endfunction

  task automatic expect_cyc(input string tag, input ctl_t v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare mid-cycle.
  task automatic step(input logic ir, input logic dr, input logic z, input logic [10:0] op);
    ctl_t  e;
    string t;
    @(negedge clk);
    bus.imemReady = ir;
    bus.dmemReady = dr;
    bus.zeroCU    = z;
    bus.opCode    = op;
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(observe()), 32'(e));
    end
  endtask

  task automatic run_instr(input kind_e k, input logic z, input int iw, input int dw);
    ctl_t        v;
    fld_t        f;
    logic [10:0] op;
    op = opcode_of(k);
    f  = fields(k);
    for (int i = 0; i < iw; i++) begin
      v = '0; v.imemRd = 1'b1;
      expect_cyc("fetch_stall", v);
      step(1'b0, 1'b0, z, 11'($urandom));
    end
    v = '0; v.imemRd = 1'b1; v.irWr = 1'b1; v.pcWr = 1'b1;
    expect_cyc("fetch", v);
    step(1'b1, 1'b0, z, 11'($urandom));
    if (k == K_ILL) begin
      expect_cyc("decode_ill", '0);
      step(1'b1, 1'b0, z, op);
      for (int i = 0; i < 3; i++) begin
        v = '0; v.illegal = 1'b1;
        expect_cyc("halt", v);
        step(1'b1, 1'b1, z, op);
      end
      return;
    end
    v = '0; v.f = f;
    expect_cyc("decode", v);
    step(1'b1, 1'b0, z, op);
    v = '0; v.f = f;
    if (k == K_B || (k == K_CBZ && z) || (k == K_CBNZ && !z)) begin
      v.pcWr = 1'b1; v.nextPc = 1'b1;
    end
    expect_cyc("exec", v);
    step(1'b1, 1'b0, z, op);
    if (k == K_LDUR || k == K_STUR) begin
      v = '0; v.f = f; v.memRd = (k == K_LDUR); v.memWr = (k == K_STUR);
      for (int i = 0; i < dw; i++) begin
        expect_cyc("mem_wait", v);
        step(1'b1, 1'b0, z, op);
      end
      expect_cyc("mem", v);
      step(1'b1, 1'b1, z, op);
    end
    if (k != K_B && k != K_CBZ && k != K_CBNZ && k != K_STUR) begin
      v = '0; v.f = f; v.regWr = 1'b1;
      expect_cyc("wb", v);
      step(1'b1, 1'b0, z, op);
    end
    ret_exp = ret_exp + 16'd1;
    @(posedge clk);
    #1;
    check("retired", 32'(bus.retired), 32'(ret_exp));
  endtask

  task automatic check_reset_quiet(input string tag);
    check(tag, 32'(observe()), 32'd0);
    check({tag, "_retired"}, 32'(bus.retired), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t        v;
    logic [10:0] op;
    rstN          = 1'b0;
    bus.opCode    = '0;
    bus.zeroCU    = 1'b0;
    bus.imemReady = 1'b0;
    bus.dmemReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_quiet("reset");
    rstN = 1'b1;
    #1;
    check("imemrd_before_edge", 32'(bus.imemRd), 32'd0);

    run_instr(K_ADD, 1'b0, 0, 0);
    run_instr(K_AND, 1'b0, 1, 0);
    run_instr(K_ORR, 1'b0, 0, 0);
    run_instr(K_SUB, 1'b1, 2, 0);
    run_instr(K_ANDI, 1'b0, 0, 0);
    run_instr(K_ADDI, 1'b0, 0, 0);
    run_instr(K_ORRI, 1'b0, 0, 0);
    run_instr(K_SUBI, 1'b0, 0, 0);
    run_instr(K_LDUR, 1'b0, 0, 2);
    run_instr(K_STUR, 1'b0, 0, 0);
    run_instr(K_LDUR, 1'b0, 0, 0);
    run_instr(K_STUR, 1'b0, 1, 3);
    run_instr(K_B, 1'b0, 0, 0);
    run_instr(K_CBZ, 1'b1, 0, 0);
    run_instr(K_CBZ, 1'b0, 0, 0);
    run_instr(K_CBNZ, 1'b0, 0, 0);
    run_instr(K_CBNZ, 1'b1, 0, 0);

    // Counter wrap: preload 0xFFFF while parked in a fetch stall.
    v = '0; v.imemRd = 1'b1;
    expect_cyc("fetch_stall", v);
    step(1'b0, 1'b0, 1'b0, 11'd0);
    force dut.retired_q = 16'hFFFF;
    expect_cyc("fetch_stall", v);
    step(1'b0, 1'b0, 1'b0, 11'd0);
    release dut.retired_q;
    ret_exp = 16'hFFFF;
    check("retired_preload", 32'(bus.retired), 32'h0000FFFF);
    run_instr(K_B, 1'b0, 0, 0);
    check("retired_wrap", 32'(bus.retired), 32'd0);

    // Reset asserted mid-STUR while the store is waiting in MEM.
    op = opcode_of(K_STUR);
    v = '0; v.imemRd = 1'b1; v.irWr = 1'b1; v.pcWr = 1'b1;
    expect_cyc("fetch", v);
    step(1'b1, 1'b0, 1'b0, 11'd0);
    v = '0; v.f = fields(K_STUR);
    expect_cyc("decode", v);
    step(1'b1, 1'b0, 1'b0, op);
    expect_cyc("exec", v);
    step(1'b1, 1'b0, 1'b0, op);
    v.memWr = 1'b1;
    expect_cyc("mem_wait", v);
    step(1'b1, 1'b0, 1'b0, op);
    rstN = 1'b0;
    #1;
    check_reset_quiet("reset_mid_stur");
    ret_exp = 16'd0;
    @(negedge clk);
    #1;
    check_reset_quiet("reset_hold");
    rstN = 1'b1;
    #1;
    check("imemrd_before_edge2", 32'(bus.imemRd), 32'd0);
    run_instr(K_ADD, 1'b0, 0, 0);

    // Illegal opcode traps in HALT until a reset pulse.
    run_instr(K_ILL, 1'b0, 0, 0);
    check("halt_retired", 32'(bus.retired), 32'(ret_exp));
    rstN = 1'b0;
    #1;
    check_reset_quiet("reset_from_halt");
    ret_exp = 16'd0;
    @(negedge clk);
    rstN = 1'b1;
    run_instr(K_B, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
